npu_axi4lite_regbank: RTL and testbench
=======================================

Name: npu_axi4lite_regbank

Overview:
Parametrised AXI4-Lite slave endpoint that terminates one bus port in a bank of N_REGS memory-mapped registers. It is the next generation of the team's AXI4-Lite bus definition: configurable widths and depth, write and read response codes, per-register read-only mapping, and independent acceptance of the write address and write data. It sits between the NPU interconnect and control/status logic, exposing flat register outputs and write pulses.

Parameters:
A_W, 16, address width in bits.
D_W, 32, data width in bits; must be 32 or 64.
N_REGS, 16, number of registers; must be ≥2 and a power of 2.
RO_MASK, {N_REGS{1'b0}}, bit i set makes register i read-only; its reads return sts_d slice i.
RST_VAL, {N_REGS*D_W{1'b0}}, reset value of the read-write registers.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
wa_valid / wa_ready  in/out  1/1  write address handshake.
wa_addr  in  A_W  write byte address.
wd_valid / wd_ready  in/out  1/1  write data handshake.
wd_data  in  D_W  write data.
wd_strb  in  D_W/8  byte enables.
wr_valid / wr_ready  out/in  1/1  write response handshake.
wr_resp  out  2  00 OKAY, 10 SLVERR.
ra_valid / ra_ready  in/out  1/1  read address handshake.
ra_addr  in  A_W  read byte address.
rd_valid / rd_ready  out/in  1/1  read data handshake.
rd_data  out  D_W  read data.
rd_resp  out  2  00 OKAY, 10 SLVERR.
reg_q  out  N_REGS*D_W  current read-write register contents; RO slices drive 0.
reg_wr  out  N_REGS  one-cycle pulse when register i is written (any strobe).
sts_d  in  N_REGS*D_W  status inputs for RO registers.

Behaviour:
- Decode: OFS = log2(D_W/8). Index = addr[OFS+log2(N_REGS)-1:OFS].
- Error (SLVERR) if addr[OFS-1:0] != 0, if any addr bit above the index field is set, or, for writes only, if the target is RO. An erroring write changes nothing and raises no reg_wr.
- Reset (rst=1 at a clock edge) gives: all ready and valid outputs 0, wr_resp=rd_resp=0, rd_data=0, reg_wr=0, reg_q=RST_VAL. Held AW/W and pending responses are dropped. Readies are forced 0 while rst=1 and may rise the first cycle after rst falls.
- Write path has three states: IDLE, COLLECT (one or both of AW/W held), RESP.
  - wa_ready = !aw_held && state!=RESP.
  - wd_ready = !w_held && state!=RESP.
  - AW and W are accepted independently in any order, or in the same cycle.
- Write commit:
  - In the first cycle both are held, commit at the next edge: byte lanes with wd_strb=1 update, reg_wr[i] pulses for that cycle, wr_valid rises, and the holders clear.
  - AW and W accepted at edge N give commit and wr_valid=1 after edge N+1.
  - wr_valid and wr_resp stay stable until wr_ready; the handshake returns to IDLE.
  - A zero strobe with a valid address responds OKAY, changes no bytes, and still pulses reg_wr.
- Read path has two states: IDLE and DATA.
  - ra_ready = (state==IDLE).
  - On acceptance at edge N, rd_data, rd_resp and rd_valid are registered at edge N.
  - RW registers read reg_q. RO registers read sts_d sampled at edge N. Error reads return 0.
  - rd_valid and rd_data stay stable until rd_ready, then return to IDLE. Throughput is one read per 2 cycles; no back-to-back acceptance while rd_valid=1.
- Simultaneous events: the read and write paths are fully independent. A read sampled at the same edge as a write commit to that register returns the pre-write value.
- No combinational path from any valid input to any ready output, except the rst gating.

Test Plan:
- Write 0xA5A5_1234 to 0x04 with AW and W in the same cycle, wr_ready=1 -> wr_valid one cycle after acceptance, wr_resp=00, reg_wr=0x0002, then a read of 0x04 returns 0xA5A5_1234 with OKAY.
- W presented 3 cycles before AW, with wd_strb=0b0100 and data 0x00FF_0000, over reg1=0xA5A5_1234 -> only byte 2 changes; reg1=0xA5FF_1234. wd_ready is 0 from W acceptance until the response completes.
- Reject cases: write to 0x06 (misaligned), to 0x40 (N_REGS=16, out of range) and to an RO register (RO_MASK bit 3, addr 0x0C) -> wr_resp=10 each time, no reg_wr pulse, reg_q unchanged. A read of 0x40 returns 0 with rd_resp=10.
- Backpressure: hold wr_ready=0 and rd_ready=0 for 5 cycles -> wr_valid, rd_valid, rd_data and responses are stable, and wa_ready, wd_ready and ra_ready are all 0. Releasing ready completes each handshake in exactly one cycle.
- Read of reg2 accepted at the same edge as a write commit of 0xDEAD_BEEF to reg2 (old value 0x0) -> rd_data=0x0, and the following read returns 0xDEAD_BEEF.
- Assert rst with AW held and a read pending -> the next cycle shows all valids 0 and reg_q=RST_VAL. After rst falls, a fresh write completes normally with no stale response.

Source files
------------

// File: rtl/npu_axi4lite_regbank.sv
// AXI4-Lite slave terminating one bus port in a bank of N_REGS registers, with per-register
// read-only status mapping, independent AW/W acceptance and registered responses.
module npu_axi4lite_regbank #(
    parameter int unsigned           A_W     = 16,
    parameter int unsigned           D_W     = 32,
    parameter int unsigned           N_REGS  = 16,
    parameter logic [N_REGS-1:0]     RO_MASK = '0,
    parameter logic [N_REGS*D_W-1:0] RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wa_valid,
    output logic                  wa_ready,
    input  logic [A_W-1:0]        wa_addr,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [D_W-1:0]        wd_data,
    input  logic [D_W/8-1:0]      wd_strb,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [1:0]            wr_resp,
    input  logic                  ra_valid,
    output logic                  ra_ready,
    input  logic [A_W-1:0]        ra_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [D_W-1:0]        rd_data,
    output logic [1:0]            rd_resp,
    output logic [N_REGS*D_W-1:0] reg_q,
    output logic [N_REGS-1:0]     reg_wr,
    input  logic [N_REGS*D_W-1:0] sts_d
);
    localparam int unsigned S_W = D_W / 8;
    localparam int unsigned OFS = $clog2(S_W);
    localparam int unsigned IW  = $clog2(N_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t        w_state, w_next;
    r_state_t        r_state, r_next;
    logic            aw_held, w_held;
    logic [A_W-1:0]  aw_addr_q;
    logic [D_W-1:0]  wd_data_q;
    logic [S_W-1:0]  wd_strb_q;
    logic [D_W-1:0]  regs [N_REGS];
    logic            aw_fire, w_fire, ra_fire, w_commit;
    logic [IW-1:0]   w_idx, r_idx;
    logic            w_err, r_err;
    logic [D_W-1:0]  r_sel;

    // Misaligned or beyond the decoded index field
    function automatic logic addr_bad(input logic [A_W-1:0] a);
        logic [A_W-1:0] lo_mask;
        lo_mask = A_W'(S_W - 1);
        return ((a & lo_mask) != '0) || ((a >> (OFS + IW)) != '0);
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [A_W-1:0] a);
        return IW'(a >> OFS);
    endfunction

    assign aw_fire  = wa_valid && wa_ready;
    assign w_fire   = wd_valid && wd_ready;
    assign ra_fire  = ra_valid && ra_ready;
    assign w_commit = (w_state == W_COLLECT) && aw_held && w_held;
    assign w_idx    = addr_idx(aw_addr_q);
    assign w_err    = addr_bad(aw_addr_q) || RO_MASK[w_idx];
    assign r_idx    = addr_idx(ra_addr);
    assign r_err    = addr_bad(ra_addr);

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:    if (aw_fire || w_fire) w_next = W_COLLECT;
            W_COLLECT: if (aw_held && w_held) w_next = W_RESP;
            W_RESP:    if (wr_ready) w_next = W_IDLE;
            default:   w_next = W_IDLE;
        endcase
    end

    always_comb begin
        wa_ready = !rst && !aw_held && (w_state != W_RESP);
        wd_ready = !rst && !w_held && (w_state != W_RESP);
        wr_valid = (w_state == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wd_data_q <= '0;
            wd_strb_q <= '0;
        end else if (w_commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= wa_addr;
            end
            if (w_fire) begin
                w_held    <= 1'b1;
                wd_data_q <= wd_data;
                wd_strb_q <= wd_strb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= RST_VAL[i*D_W +: D_W];
            reg_wr  <= '0;
            wr_resp <= RESP_OKAY;
        end else begin
            reg_wr <= '0;
            if (w_commit) begin
                wr_resp <= w_err ? RESP_SLVERR : RESP_OKAY;
                if (!w_err) begin
                    reg_wr[w_idx] <= 1'b1;
                    for (int unsigned b = 0; b < S_W; b++)
                        if (wd_strb_q[b]) regs[w_idx][b*8 +: 8] <= wd_data_q[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ra_fire) r_next = R_DATA;
            R_DATA:  if (rd_ready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        ra_ready = !rst && (r_state == R_IDLE);
        rd_valid = (r_state == R_DATA);
    end

    // RO slots read live status; RW slots read the pre-commit register value
    always_comb begin
        r_sel = '0;
        for (int unsigned i = 0; i < N_REGS; i++)
            if (IW'(i) == r_idx) r_sel = RO_MASK[i] ? sts_d[i*D_W +: D_W] : regs[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_resp <= RESP_OKAY;
        end else if (ra_fire) begin
            rd_data <= r_err ? '0 : r_sel;
            rd_resp <= r_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < N_REGS; i++)
            reg_q[i*D_W +: D_W] = RO_MASK[i] ? '0 : regs[i];
    end
endmodule

// File: tb/tb_npu_axi4lite_regbank.sv
// Scoreboard bench for npu_axi4lite_regbank: stimulus pushes expected responses computed
// from a word-array model; a negedge monitor pops and compares at each handshake.
module tb_npu_axi4lite_regbank;
    localparam int unsigned A_W = 16;
    localparam int unsigned D_W = 32;
    localparam int unsigned N_REGS = 16;
    localparam logic [15:0] RO = 16'h0008;
    localparam logic [511:0] RSTV = {32'hC0DE_0F0F, {11{32'h0}}, 32'hFFFF_FFFF,
                                     32'h0, 32'h0, 32'h1357_9BDF};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wa_valid, wa_ready, wd_valid, wd_ready, wr_valid, wr_ready;
    logic ra_valid, ra_ready, rd_valid, rd_ready;
    logic [15:0] wa_addr, ra_addr, reg_wr;
    logic [31:0] wd_data, rd_data;
    logic [3:0]  wd_strb;
    logic [1:0]  wr_resp, rd_resp;
    logic [511:0] reg_q, sts_d;

    always #5 clk = ~clk;

    npu_axi4lite_regbank #(
        .A_W(A_W), .D_W(D_W), .N_REGS(N_REGS), .RO_MASK(RO), .RST_VAL(RSTV)
    ) dut (
        .clk(clk), .rst(rst),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_resp(wr_resp),
        .ra_valid(ra_valid), .ra_ready(ra_ready), .ra_addr(ra_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
        .reg_q(reg_q), .reg_wr(reg_wr), .sts_d(sts_d)
    );

    typedef struct { logic [1:0] resp; logic [15:0] mask; } wexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];
    logic [31:0] model [16];
    int n_tests = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endfunction

    function automatic void chk_regq(input string name);
        logic [511:0] e;
        e = '0;
        for (int i = 0; i < 16; i++) if (!RO[i]) e[i*32 +: 32] = model[i];
        n_tests++;
        if (reg_q !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, reg_q, e);
        end
    endfunction

    function automatic bit addr_err(input logic [15:0] a, input bit is_wr);
        if ((a % 16'd4) != 16'd0 || a >= 16'h40) return 1'b1;
        return is_wr && RO[a >> 2];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) model[i] = RSTV[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int gap);
        int aw_at, w_at, t, idx;
        bit aw_d, w_d;
        aw_at = (gap > 0) ? gap : 0;
        w_at  = (gap < 0) ? -gap : 0;
        aw_d = 1'b0; w_d = 1'b0; t = 0;
        wa_addr = a; wd_data = d; wd_strb = s;
        while (!(aw_d && w_d) && t < 40) begin
            wa_valid = !aw_d && (t >= aw_at);
            wd_valid = !w_d && (t >= w_at);
            @(negedge clk);
            if (w_d)  chk("wd_ready_while_held", 32'(wd_ready), 32'd0);
            if (aw_d) chk("wa_ready_while_held", 32'(wa_ready), 32'd0);
            if (wa_valid && wa_ready) aw_d = 1'b1;
            if (wd_valid && wd_ready) w_d = 1'b1;
            if (aw_d && w_d) begin
                if (addr_err(a, 1'b1)) wq.push_back('{2'b10, 16'h0000});
                else begin
                    idx = int'(a >> 2);
                    for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
                    wq.push_back('{2'b00, 16'(1 << idx)});
                end
            end
            tick();
            t++;
        end
        wa_valid = 1'b0;
        wd_valid = 1'b0;
        if (!(aw_d && w_d)) begin
            fail("write_accept_timeout");
            return;
        end
        @(negedge clk);
        chk("wr_valid_before_commit", 32'(wr_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("wr_valid_after_commit", 32'(wr_valid), 32'd1);
        tick();
    endtask

    task automatic do_read(input logic [15:0] a);
        bit done;
        int t, idx;
        rexp_t e;
        done = 1'b0; t = 0;
        ra_addr = a;
        ra_valid = 1'b1;
        while (!done && t < 40) begin
            @(negedge clk);
            if (ra_ready) begin
                done = 1'b1;
                if (addr_err(a, 1'b0)) e = '{32'h0, 2'b10};
                else begin
                    idx = int'(a >> 2);
                    e = '{RO[idx] ? sts_d[idx*32 +: 32] : model[idx], 2'b00};
                end
                rq.push_back(e);
            end
            tick();
            t++;
        end
        ra_valid = 1'b0;
        if (!done) begin
            fail("read_accept_timeout");
            return;
        end
        @(negedge clk);
        chk("rd_valid_latency", 32'(rd_valid), 32'd1);
        tick();
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < 200) begin
            if (rnd) begin
                wr_ready = ($urandom_range(0, 3) != 0);
                rd_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
        end
        if (wq.size() != 0 || rq.size() != 0) begin
            fail("drain_timeout");
            wq.delete();
            rq.delete();
        end
        wr_ready = 1'b1;
        rd_ready = 1'b1;
    endtask

    task automatic rand_sts();
        for (int i = 0; i < 16; i++) sts_d[i*32 +: 32] = $urandom();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_readies"}, 32'({wa_ready, wd_ready, ra_ready}), 32'd0);
        chk({tag, "_valids"}, 32'({wr_valid, rd_valid}), 32'd0);
        chk({tag, "_resps"}, 32'({wr_resp, rd_resp}), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_reg_wr"}, 32'(reg_wr), 32'd0);
        chk_regq({tag, "_reg_q"});
    endtask

    bit w_pend = 1'b0;
    bit r_pend = 1'b0;
    logic [1:0] last_wresp, last_rresp;
    logic [31:0] last_rdata;
    wexp_t wtop;
    rexp_t rtop;

    always @(negedge clk) begin
        if (rst) begin
            wq.delete();
            rq.delete();
            w_pend = 1'b0;
            r_pend = 1'b0;
        end else begin
            if (w_pend) begin
                chk("wr_valid_hold", 32'(wr_valid), 32'd1);
                chk("wr_resp_stable", 32'(wr_resp), 32'(last_wresp));
            end
            if (wr_valid) begin
                chk("w_readies_in_resp", 32'({wa_ready, wd_ready}), 32'd0);
                if (!w_pend) begin
                    if (wq.size() == 0) fail("unexpected_wr_response");
                    else chk("reg_wr", 32'(reg_wr), 32'(wq[0].mask));
                end
                if (wr_ready && wq.size() != 0) begin
                    wtop = wq.pop_front();
                    chk("wr_resp", 32'(wr_resp), 32'(wtop.resp));
                end
            end
            if (!(wr_valid && !w_pend)) chk("reg_wr_idle", 32'(reg_wr), 32'd0);
            w_pend = wr_valid && !wr_ready;
            last_wresp = wr_resp;

            if (r_pend) begin
                chk("rd_valid_hold", 32'(rd_valid), 32'd1);
                chk("rd_data_stable", rd_data, last_rdata);
                chk("rd_resp_stable", 32'(rd_resp), 32'(last_rresp));
            end
            if (rd_valid) begin
                chk("ra_ready_while_valid", 32'(ra_ready), 32'd0);
                if (rd_ready) begin
                    if (rq.size() == 0) fail("unexpected_rd_response");
                    else begin
                        rtop = rq.pop_front();
                        chk("rd_data", rd_data, rtop.data);
                        chk("rd_resp", 32'(rd_resp), 32'(rtop.resp));
                    end
                end
            end
            r_pend = rd_valid && !rd_ready;
            last_rdata = rd_data;
            last_rresp = rd_resp;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        int sel, g;
        wa_valid = 1'b0; wd_valid = 1'b0; ra_valid = 1'b0;
        wa_addr = '0; ra_addr = '0; wd_data = '0; wd_strb = '0;
        wr_ready = 1'b1; rd_ready = 1'b1;
        rand_sts();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("por");
        tick();
        rst = 1'b0;

        // Same-cycle AW/W, then readback
        do_write(16'h0004, 32'hA5A5_1234, 4'hF, 0);
        drain(1'b0);
        chk("t1_reg1", reg_q[63:32], 32'hA5A5_1234);
        chk_regq("t1_regq");
        do_read(16'h0004);
        drain(1'b0);

        // W three cycles ahead of AW, single byte lane
        do_write(16'h0004, 32'h00FF_0000, 4'b0100, 3);
        drain(1'b0);
        chk("t2_reg1", reg_q[63:32], 32'hA5FF_1234);
        chk_regq("t2_regq");

        // Rejected writes and reads
        do_write(16'h0006, 32'h1111_1111, 4'hF, 0);
        drain(1'b0);
        do_write(16'h0040, 32'h2222_2222, 4'hF, -2);
        drain(1'b0);
        do_write(16'h000C, 32'h3333_3333, 4'hF, 1);
        drain(1'b0);
        chk_regq("t3_regq");
        do_read(16'h0040);
        drain(1'b0);
        do_read(16'h000C);
        drain(1'b0);

        // Backpressure on both response channels
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        do_write(16'h0010, 32'h0BAD_F00D, 4'hF, -1);
        do_read(16'h0014);
        repeat (5) begin
            @(negedge clk);
            chk("bp_readies", 32'({wa_ready, wd_ready, ra_ready}), 32'd0);
            chk("bp_valids", 32'({wr_valid, rd_valid}), 32'd3);
            tick();
        end
        wr_ready = 1'b1;
        rd_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_release", 32'({wr_valid, rd_valid}), 32'd0);
        chk("bp_queues", 32'(wq.size() + rq.size()), 32'd0);
        tick();

        // Read accepted on the commit edge of a write to the same register
        wa_addr = 16'h0008; wd_data = 32'hDEAD_BEEF; wd_strb = 4'hF;
        wa_valid = 1'b1; wd_valid = 1'b1;
        @(negedge clk);
        chk("col_accept", 32'({wa_ready, wd_ready}), 32'd3);
        wq.push_back('{2'b00, 16'h0004});
        tick();
        wa_valid = 1'b0; wd_valid = 1'b0;
        ra_addr = 16'h0008; ra_valid = 1'b1;
        @(negedge clk);
        chk("col_ra_ready", 32'(ra_ready), 32'd1);
        rq.push_back('{model[2], 2'b00});
        model[2] = 32'hDEAD_BEEF;
        tick();
        ra_valid = 1'b0;
        drain(1'b0);
        do_read(16'h0008);
        drain(1'b0);

        // Reset with AW held and a read response pending
        rd_ready = 1'b0;
        wa_addr = 16'h0020; wa_valid = 1'b1; wd_valid = 1'b0;
        @(negedge clk);
        chk("rst_aw_accept", 32'(wa_ready), 32'd1);
        tick();
        wa_valid = 1'b0;
        do_read(16'h0000);
        rst = 1'b1;
        tick();
        @(negedge clk);
        model_reset();
        check_reset_state("mid");
        tick();
        rst = 1'b0;
        rd_ready = 1'b1;
        do_write(16'h0008, 32'h600D_CAFE, 4'hF, 2);
        drain(1'b0);
        chk_regq("post_rst_regq");
        do_read(16'h0008);
        drain(1'b0);
        do_read(16'h0000);
        drain(1'b0);

        // Randomised traffic against the model
        for (int k = 0; k < 120; k++) begin
            rand_sts();
            wr_ready = ($urandom_range(0, 1) != 0);
            rd_ready = ($urandom_range(0, 1) != 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       a = 16'($urandom_range(0, 15) * 4);
            else if (sel == 7) a = 16'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else               a = 16'($urandom_range(16'h0040, 16'hFFFF));
            if ($urandom_range(0, 1) != 0) begin
                g = int'($urandom_range(0, 6)) - 3;
                do_write(a, $urandom(), 4'($urandom_range(0, 15)), g);
                drain(1'b1);
                chk_regq("rnd_regq");
            end else begin
                do_read(a);
                drain(1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
